edac_encoder: RTL and testbench

- Write-side counterpart of the EDAC read path; sits on the store path to the protected memory/LUT.
- Accepts an 8-bit data byte and computes an 8-bit CRC over it using a run-time polynomial, bit-serially, one division step per cycle.
- Wraps {data, crc} in a 21-bit Hamming codeword with parity at bit positions 0, 1, 3, 7 and 15.
- Emits the codeword zero-extended to 32 bits, plus a copy for priming the LUT, over a valid/ready handshake.

---
 rtl/edac_pkg.sv | 52 +++++
 rtl/edac_crc_serial.sv | 58 +++++
 rtl/edac_encoder.sv | 87 ++++++++
 tb/tb_edac_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edac_pkg.sv
// Shared EDAC definitions: codeword geometry, data/CRC bit placement and
// Hamming parity helpers used by both the encoder and the decoder.
package edac_pkg;

  localparam int CRC_W  = 8;
  localparam int DATA_W = 8;
  localparam int WORD_W = DATA_W + CRC_W;
  localparam int CODE_W = 21;
  localparam int PAR_N  = 5;

  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

  // W[i] lands in codeword bit DATA_POS[i]; parity owns the power-of-two slots
  localparam logic [4:0] DATA_POS [WORD_W] = '{
    5'd2,  5'd4,  5'd5,  5'd6,  5'd8,  5'd9,  5'd10, 5'd11,
    5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20
  };
  localparam logic [4:0] PAR_POS [PAR_N] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd15};
  localparam logic [CODE_W-1:0] PAR_MASK [PAR_N] = '{
    21'h155554, 21'h066664, 21'h187870, 21'h007F00, 21'h1F0000
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CRC,
    ST_HAM,
    ST_DONE
  } enc_state_e;

  function automatic logic [CODE_W-1:0] place_data_crc(input logic [WORD_W-1:0] w);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c[DATA_POS[4'(i)]] = w[4'(i)];
    return c;
  endfunction

  function automatic logic [CODE_W-1:0] add_parity(input logic [CODE_W-1:0] c);
    logic [CODE_W-1:0] r;
    r = c;
    for (int j = 0; j < PAR_N; j++) r[PAR_POS[3'(j)]] = ^(c & PAR_MASK[3'(j)]);
    return r;
  endfunction

  // Zero for a clean codeword, otherwise the 1-based position of a single flip
  function automatic logic [4:0] syndrome(input logic [CODE_W-1:0] c);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < CODE_W; i++) if (c[5'(i)]) s = s ^ 5'(i + 1);
    return s;
  endfunction

endpackage

// File: rtl/edac_crc_serial.sv
// Bit-serial CRC divider: one division step per enabled cycle over a 16-bit
// shift register loaded with {data, 8'h00}.
module edac_crc_serial
  import edac_pkg::*;
#(
  parameter int CRC_STEPS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [CRC_W-1:0]  poly,
  output logic              done,
  output logic [CRC_W-1:0]  crc
);

  localparam logic [3:0] K_FIRST = 4'd15;
  localparam logic [3:0] K_LAST  = 4'd8;

  generate
    if (CRC_STEPS != 8) begin : g_steps_check
      $error("edac_crc_serial: CRC_STEPS must be 8");
    end
  endgenerate

  logic [WORD_W-1:0] t;
  logic [WORD_W-1:0] p_shifted;
  logic [3:0]        k;
  logic [CRC_W-1:0]  p;
  logic              running;
  logic              step;

  assign step      = en && running;
  assign done      = step && (k == K_LAST);
  assign crc       = t[CRC_W-1:0];
  assign p_shifted = {8'h00, p} << (k - 4'd7);

  // done is asserted during the k=8 step so the caller can move on at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t       <= '0;
      k       <= '0;
      p       <= '0;
      running <= 1'b0;
    end else if (start && !running) begin
      t       <= {data, 8'h00};
      k       <= K_FIRST;
      p       <= poly;
      running <= 1'b1;
    end else if (step) begin
      if (t[k]) t <= t ^ p_shifted;
      k <= k - 4'd1;
      if (k == K_LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/edac_encoder.sv
// EDAC write-side encoder: serial CRC over the data byte, then a 21-bit
// Hamming codeword of {data, crc} presented on a valid/ready output.
module edac_encoder
  import edac_pkg::*;
#(
  parameter logic [7:0] DEFAULT_POLY = 8'h83,
  parameter int         CRC_STEPS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Din,
  input  logic [7:0]  CRC_POLY,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Dout,
  output logic [31:0] LUT_OUT,
  output logic        busy
);

  enc_state_e state, next_state;

  logic              armed;
  logic              accept;
  logic              crc_done;
  logic [7:0]        d_reg;
  logic [7:0]        crc;
  logic [7:0]        poly_eff;
  logic [CODE_W-1:0] code;

  assign accept   = in_valid && in_ready;
  assign poly_eff = (CRC_POLY == 8'h00) ? DEFAULT_POLY : CRC_POLY;
  assign code     = add_parity(place_data_crc({d_reg, crc}));

  edac_crc_serial #(.CRC_STEPS(CRC_STEPS)) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (accept),
    .data  (Din),
    .poly  (poly_eff),
    .done  (crc_done),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else if (en) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept)    next_state = ST_CRC;
      ST_CRC:  if (crc_done)  next_state = ST_HAM;
      ST_HAM:                 next_state = ST_DONE;
      ST_DONE: if (out_ready) next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // armed keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = en && armed && (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      d_reg   <= '0;
      Dout    <= '0;
      LUT_OUT <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) d_reg <= Din;
      if (en && state == ST_HAM) begin
        Dout    <= {{(32-CODE_W){1'b0}}, code};
        LUT_OUT <= {{(32-CODE_W){1'b0}}, code};
      end
    end
  end

endmodule

// File: tb/tb_edac_encoder.sv
// Self-checking bench for edac_encoder against a generic Hamming/CRC model.
module tb_edac_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Din;
  logic [7:0]  CRC_POLY;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Dout;
  logic [31:0] LUT_OUT;
  logic        busy;

  int tests = 0;
  int fails = 0;

  edac_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Din       (Din),
    .CRC_POLY  (CRC_POLY),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Dout      (Dout),
    .LUT_OUT   (LUT_OUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Long division as stated: clear against P shifted under each set bit, k=15..8
  function automatic logic [7:0] model_crc(input logic [7:0] d, input logic [7:0] p);
    int t, pe;
    pe = (p == 8'h00) ? 32'h83 : int'(p);
    t  = int'(d) << 8;
    for (int k = 15; k >= 8; k--)
      if (((t >> k) & 1) == 1) t = (t ^ (pe << (k - 7))) & 32'hFFFF;
    return t[7:0];
  endfunction

  // Textbook Hamming: data fills non-power-of-two 1-based positions in order
  function automatic logic [31:0] model_code(input logic [7:0] d, input logic [7:0] p);
    logic [15:0] w;
    logic [31:0] c;
    int          n;
    bit          par;
    w = {d, model_crc(d, p)};
    c = '0;
    n = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = w[n];
        n++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 21; pos++)
        if ((pos & (1 << j)) != 0) par ^= c[pos-1];
      c[(1 << j) - 1] = par;
    end
    return c;
  endfunction

  function automatic int model_syndrome(input logic [31:0] c);
    int s;
    s = 0;
    for (int pos = 1; pos <= 21; pos++) if (c[pos-1]) s ^= pos;
    return s;
  endfunction

  // Drives one byte through the accept edge and counts edges until out_valid
  task automatic encode_byte(input logic [7:0] d, input logic [7:0] p, input bit pause,
                             output logic [31:0] code, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("[TB] FAIL in_ready_wait: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    Din = d; CRC_POLY = p; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; Din = 8'($urandom); CRC_POLY = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (pause && lat == 3) en = 1'b0;
      if (pause && lat == 8) en = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("[TB] FAIL out_valid_wait: out_valid=%b required 1 within 60 cycles", out_valid);
    end
    code = Dout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; Din = '0; CRC_POLY = '0;
    #3;
    tests++;
    if ({Dout, LUT_OUT, out_valid, in_ready, busy} !== {32'h0, 32'h0, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset_state: Dout=%h LUT=%h ov=%b ir=%b busy=%b required all 0",
               Dout, LUT_OUT, out_valid, in_ready, busy);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_edge: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_zero_byte();
    logic [31:0] code;
    int lat;
    encode_byte(8'h00, 8'h83, 1'b0, code, lat);
    tests++;
    if (lat !== 9 || code !== 32'h0 || LUT_OUT !== 32'h0) begin
      fails++;
      $display("[TB] FAIL zero_byte: lat=%0d Dout=%h LUT=%h required 9 / 0 / 0", lat, code, LUT_OUT);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL zero_handoff: ov=%b ir=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_known_vector();
    logic [31:0] code;
    int lat;
    encode_byte(8'h01, 8'h83, 1'b0, code, lat);
    tests++;
    if (code !== 32'h0000_10BA || LUT_OUT !== 32'h0000_10BA) begin
      fails++;
      $display("[TB] FAIL known_01_83: Dout=%h LUT=%h required 000010ba", code, LUT_OUT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_default_poly();
    logic [31:0] c0, c83;
    logic [7:0]  d;
    int lat;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      encode_byte(d, 8'h00, 1'b0, c0, lat);
      @(posedge clk); #1;
      encode_byte(d, 8'h83, 1'b0, c83, lat);
      @(posedge clk); #1;
      tests++;
      if (c0 !== c83 || c0 !== model_code(d, 8'h83)) begin
        fails++;
        $display("[TB] FAIL default_poly d=%h: poly0=%h poly83=%h required %h",
                 d, c0, c83, model_code(d, 8'h83));
      end
    end
  endtask

  // Random bytes back to back with out_ready held high
  task automatic test_random_back_to_back();
    logic [7:0]  polys [3] = '{8'h83, 8'h07, 8'hD5};
    logic [7:0]  d, p;
    logic [31:0] code, exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      p = (i % 4 == 3) ? 8'($urandom) : polys[i % 3];
      exp = model_code(d, p);
      encode_byte(d, p, 1'b0, code, lat);
      tests++;
      if (code !== exp || LUT_OUT !== exp || lat !== 9) begin
        fails++;
        $display("[TB] FAIL random d=%h p=%h: Dout=%h LUT=%h lat=%0d required %h lat 9",
                 d, p, code, LUT_OUT, lat, exp);
      end
      tests++;
      if (model_syndrome(code) != 0) begin
        fails++;
        $display("[TB] FAIL syndrome d=%h p=%h: syndrome=%0d required 0", d, p, model_syndrome(code));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] code, exp;
    int lat, bad;
    out_ready = 1'b0;
    exp = model_code(8'hA7, 8'h07);
    encode_byte(8'hA7, 8'h07, 1'b0, code, lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; Din = 8'($urandom); CRC_POLY = 8'($urandom);
      @(posedge clk); #1;
      if (Dout !== exp || LUT_OUT !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL backpressure_hold: %0d bad cycles, Dout=%h required %h held", bad, Dout, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || Dout !== exp) begin
      fails++;
      $display("[TB] FAIL backpressure_release: ov=%b ir=%b busy=%b Dout=%h required 0 1 0 %h",
               out_valid, in_ready, busy, Dout, exp);
    end
  endtask

  task automatic test_enable_pause();
    logic [31:0] code, exp;
    int lat;
    exp = model_code(8'h3C, 8'hD5);
    encode_byte(8'h3C, 8'hD5, 1'b1, code, lat);
    tests++;
    if (lat !== 14 || code !== exp) begin
      fails++;
      $display("[TB] FAIL enable_pause: lat=%0d Dout=%h required 14 %h", lat, code, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] code, exp;
    int lat;
    Din = 8'h5A; CRC_POLY = 8'h83; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || Dout === 32'h0) begin
      fails++;
      $display("[TB] FAIL mid_crc_busy: busy=%b Dout=%h required 1 and nonzero", busy, Dout);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || Dout !== 32'h0 || LUT_OUT !== 32'h0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: ov=%b Dout=%h LUT=%h busy=%b required 0 0 0 0",
               out_valid, Dout, LUT_OUT, busy);
    end
    #2 rst_n = 1'b1;
    exp = model_code(8'hC3, 8'h07);
    encode_byte(8'hC3, 8'h07, 1'b0, code, lat);
    tests++;
    if (code !== exp || lat !== 9) begin
      fails++;
      $display("[TB] FAIL after_reset: Dout=%h lat=%0d required %h 9", code, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero_byte();
    test_known_vector();
    test_default_poly();
    test_random_back_to_back();
    test_backpressure();
    test_enable_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
